// File: rtl/tinyvga_dither_out_pkg.sv
// Shared constants for the TinyVGA dithered output stage: pattern encodings,
// the 4x4 ordered-dither matrix and the PMOD pin map.
package tinyvga_dither_out_pkg;

    // Encodings of the pattern selector input.
    typedef enum logic [1:0] {
        PAT_PASS  = 2'd0,
        PAT_GREY  = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

    // Bayer 4x4 matrix, row-major, entry {y,x} in nibble (y*4 + x).
    // Rows: 0,8,2,10 / 12,4,14,6 / 3,11,1,9 / 15,7,13,5
    localparam logic [63:0] BAYER_TABLE = 64'h5D7F_91B3_6E4C_A280;

    // Bit positions on the TinyVGA PMOD byte.
    localparam int PMOD_HSYNC = 7;
    localparam int PMOD_B0    = 6;
    localparam int PMOD_G0    = 5;
    localparam int PMOD_R0    = 4;
    localparam int PMOD_VSYNC = 3;
    localparam int PMOD_B1    = 2;
    localparam int PMOD_G1    = 1;
    localparam int PMOD_R1    = 0;

    // Dither threshold for matrix cell (yi, xi), scaled by 4 (range 0..60).
    function automatic logic [5:0] bayer_threshold(input logic [1:0] yi, input logic [1:0] xi);
        logic [63:0] shifted;
        shifted = BAYER_TABLE >> {yi, xi, 2'b00};
        return {shifted[3:0], 2'b00};
    endfunction

endpackage

// File: rtl/tinyvga_dither_out_quant.sv
// Per-channel quantiser: 8-bit colour plus threshold down to a 2-bit level.
module dither_quant #(
    parameter bit DITHER_EN = 1'b1
) (
    input  logic [7:0] i_c,
    input  logic [5:0] i_t,
    output logic [1:0] o_q
);

    logic [8:0] w_sum;

    // Add the threshold in 9 bits so 255+60 cannot wrap, then clamp to level 3.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_sum = {1'b0, i_c} + {3'b000, i_t};
        o_q   = i_c[7:6];
        if (DITHER_EN) begin
            if (w_sum[8:6] >= 3'd3) begin
                o_q = 2'd3;
            end else begin
                o_q = w_sum[7:6];
            end
        end
    end

endmodule

// File: rtl/tinyvga_dither_out.sv
// TinyVGA output stage: test-pattern mux, ordered (optionally temporal)
// dither to 2 bits per channel, blanking and sync polarity, registered onto
// the PMOD byte with a fixed 2-cycle latency for sync, blanking and colour.
module tinyvga_dither_out
    import tinyvga_dither_out_pkg::*;
#(
    parameter bit DITHER_EN   = 1'b1,
    parameter bit TEMPORAL_EN = 1'b1,
    parameter bit SYNC_INVERT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    input  logic [1:0] pattern_sel,
    output logic [7:0] uo_out
);

    // Frame-level state.
    logic       r_vsync_prev;
    logic [1:0] r_frame_cnt;
    pattern_e   r_active_pat;

    // Stage 1: selected source colour, threshold, blanking and sync.
    logic [7:0] r_s1_r, r_s1_g, r_s1_b;
    logic [5:0] r_s1_t;
    logic       r_s1_de, r_s1_hs, r_s1_vs;

    // Stage 2: PMOD output byte.
    logic [7:0] r_uo;

    logic       w_vsync_rise;
    logic [2:0] w_bar;
    logic       w_chk;
    logic [7:0] w_src_r, w_src_g, w_src_b;
    logic [1:0] w_xi, w_yi;
    logic [5:0] w_t;
    logic [1:0] w_q_r, w_q_g, w_q_b;
    logic [7:0] w_uo;

    // Only the low two bits and bit 5 of vpos feed the pattern and dither logic.
    logic w_unused_vpos;
    assign w_unused_vpos = &{1'b0, vpos[9:6], vpos[4:2]};

    assign w_vsync_rise = vsync_in & ~r_vsync_prev;
    assign w_bar        = hpos[9:7];
    assign w_chk        = hpos[5] ^ vpos[5];

    // Source mux and dither-matrix index for the incoming pixel.
    always_comb begin
        w_src_r = r_in;
        w_src_g = g_in;
        w_src_b = b_in;
        case (r_active_pat)
            PAT_GREY: begin
                w_src_r = hpos[9:2];
                w_src_g = hpos[9:2];
                w_src_b = hpos[9:2];
            end
            PAT_BARS: begin
                w_src_r = {8{w_bar[2]}};
                w_src_g = {8{w_bar[1]}};
                w_src_b = {8{w_bar[0]}};
            end
            PAT_CHECK: begin
                w_src_r = {8{w_chk}};
                w_src_g = {8{w_chk}};
                w_src_b = {8{w_chk}};
            end
            default: ;
        endcase
        w_xi = hpos[1:0] + (TEMPORAL_EN ? r_frame_cnt : 2'd0);
        w_yi = vpos[1:0] + (TEMPORAL_EN ? r_frame_cnt : 2'd0);
        w_t  = bayer_threshold(w_yi, w_xi);
    end

    // Frame counter and pattern latch advance once per vsync rising edge.
    always_ff @(posedge clk) begin
        // NOTE: synchronous reset, and non-blocking assignments for all state.
        if (!rst_n) begin
            r_vsync_prev <= 1'b0;
            r_frame_cnt  <= 2'd0;
            r_active_pat <= PAT_PASS;
        end else begin
            r_vsync_prev <= vsync_in;
            if (w_vsync_rise) begin
                r_frame_cnt  <= r_frame_cnt + 2'd1;
                r_active_pat <= pattern_e'(pattern_sel);
            end
        end
    end

    // Stage-1 pipeline register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_r  <= 8'd0;
            r_s1_g  <= 8'd0;
            r_s1_b  <= 8'd0;
            r_s1_t  <= 6'd0;
            r_s1_de <= 1'b0;
            r_s1_hs <= 1'b0;
            r_s1_vs <= 1'b0;
        end else begin
            r_s1_r  <= w_src_r;
            r_s1_g  <= w_src_g;
            r_s1_b  <= w_src_b;
            r_s1_t  <= w_t;
            r_s1_de <= display_on;
            r_s1_hs <= hsync_in;
            r_s1_vs <= vsync_in;
        end
    end

    dither_quant #(.DITHER_EN(DITHER_EN)) u_quant_r (.i_c(r_s1_r), .i_t(r_s1_t), .o_q(w_q_r));
    dither_quant #(.DITHER_EN(DITHER_EN)) u_quant_g (.i_c(r_s1_g), .i_t(r_s1_t), .o_q(w_q_g));
    dither_quant #(.DITHER_EN(DITHER_EN)) u_quant_b (.i_c(r_s1_b), .i_t(r_s1_t), .o_q(w_q_b));

    // Assemble the PMOD byte; blanking forces every colour bit low.
    always_comb begin
        w_uo             = 8'h00;
        w_uo[PMOD_HSYNC] = r_s1_hs ^ SYNC_INVERT;
        w_uo[PMOD_VSYNC] = r_s1_vs ^ SYNC_INVERT;
        if (r_s1_de) begin
            w_uo[PMOD_R1] = w_q_r[1];
            w_uo[PMOD_R0] = w_q_r[0];
            w_uo[PMOD_G1] = w_q_g[1];
            w_uo[PMOD_G0] = w_q_g[0];
            w_uo[PMOD_B1] = w_q_b[1];
            w_uo[PMOD_B0] = w_q_b[0];
        end
    end

    // Stage-2 output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_uo <= 8'h00;
        end else begin
            r_uo <= w_uo;
        end
    end

    assign uo_out = r_uo;

endmodule

// File: tb/tb_tinyvga_dither_out.sv
// Directed bench for tinyvga_dither_out. Two instances share the stimulus:
// dut_a uses the defaults, dut_b plain truncation, no temporal rotation and
// inverted syncs. Expected bytes are queued when a pixel is driven and
// compared two clock edges later.
module tb_tinyvga_dither_out;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hpos, vpos;
    logic       display_on, hsync_in, vsync_in;
    logic [7:0] r_in, g_in, b_in;
    logic [1:0] pattern_sel;
    logic [7:0] uo_a, uo_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    typedef struct {
        int         due;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    tinyvga_dither_out dut_a (
        .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .pattern_sel(pattern_sel), .uo_out(uo_a)
    );

    tinyvga_dither_out #(.DITHER_EN(1'b0), .TEMPORAL_EN(1'b0), .SYNC_INVERT(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .pattern_sel(pattern_sel), .uo_out(uo_b)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample #1 later, and retire any due expectations.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        while (sb.size() > 0 && sb[0].due <= cycle) begin
            e = sb.pop_front();
            check({e.tag, "_a"}, uo_a, e.exp_a);
            check({e.tag, "_b"}, uo_b, e.exp_b);
        end
    endtask

    task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic de,
                       input logic hs, input logic vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input string tag, input logic [7:0] ea, input logic [7:0] eb);
        exp_t e;
        hpos = h; vpos = v; display_on = de; hsync_in = hs; vsync_in = vs;
        r_in = r; g_in = g; b_in = b;
        e.due = cycle + 2; e.exp_a = ea; e.exp_b = eb; e.tag = tag;
        sb.push_back(e);
        tick();
    endtask

    // Vsync held high for n cycles (blanked), then released.
    task automatic vsync_pulse(input int n, input string tag);
        pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, tag, 8'h08, 8'h80);
        for (int i = 1; i < n; i++) tick();
        vsync_in = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0; hpos = '0; vpos = '0; display_on = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0; r_in = '0; g_in = '0; b_in = '0;
        pattern_sel = 2'd0;
        for (int i = 0; i < 3; i++) tick();
        check("reset_a", uo_a, 8'h00);
        check("reset_b", uo_b, 8'h00);
        rst_n = 1'b1;

        // Pass-through, frame 0.
        pix(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h80, 8'h80, "mid_grey", 8'h07, 8'h8F);
        pix(10'd0, 10'd3, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, "sat_t60", 8'h77, 8'hFF);
        pix(10'd3, 10'd0, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C, 8'h3C, "t40_hs", 8'hF0, 8'h08);
        pix(10'd1, 10'd2, 1'b1, 1'b0, 1'b0, 8'h40, 8'hC0, 8'h00, "mixed_rgb", 8'h32, 8'hBA);
        pix(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'hFF, "blank", 8'h80, 8'h08);

        // Two lines of vsync: frame 0 -> 1, pattern stays pass.
        vsync_pulse(1600, "vs_long");
        pix(10'd3, 10'd3, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h3C, "temporal_f1", 8'h00, 8'h88);
        pix(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h3C, "temporal_t16", 8'h70, 8'h88);

        // Pattern change mid-frame must not take effect yet.
        pattern_sel = 2'd3;
        pix(10'd32, 10'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "pat_hold", 8'h00, 8'h88);
        vsync_pulse(10, "vs_chk");
        pix(10'd32, 10'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "chk_white", 8'h77, 8'hFF);
        pix(10'd32, 10'd32, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, "chk_black", 8'h00, 8'h88);
        pix(10'd0, 10'd32, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "chk_white2", 8'h77, 8'hFF);

        // Grey ramp, frame 3.
        pattern_sel = 2'd1;
        vsync_pulse(10, "vs_grey");
        pix(10'd256, 10'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "grey_40", 8'h70, 8'hF8);
        pix(10'd1020, 10'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "grey_ff", 8'h77, 8'hFF);

        // Colour bars, frame counter wraps to 0.
        pattern_sel = 2'd2;
        vsync_pulse(10, "vs_bars");
        pix(10'd640, 10'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "bars_5", 8'h55, 8'hDD);
        pix(10'd129, 10'd2, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF, "bars_1", 8'h44, 8'hCC);

        // Back to pass-through, frame 1 again after the wrap.
        pattern_sel = 2'd0;
        vsync_pulse(10, "vs_wrap");
        pix(10'd3, 10'd3, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h3C, 8'h3C, "wrap_f1", 8'h00, 8'h88);

        // Reset in the middle of a visible line.
        tick(); tick();
        hpos = 10'd0; vpos = 10'd0; display_on = 1'b1; hsync_in = 1'b1;
        r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
        rst_n = 1'b0;
        pattern_sel = 2'd3;
        tick();
        check("rst_mid_a", uo_a, 8'h00);
        check("rst_mid_b", uo_b, 8'h00);
        tick();
        rst_n = 1'b1;
        pix(10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 8'h80, 8'h80, 8'h80, "post_rst", 8'h07, 8'h8F);

        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL drain: observed %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tinyvga_dither_out.md
TINYVGA_DITHER_OUT -- requirements
Module: tinyvga_dither_out

Interface
REQ-001 The block SHALL have parameter DITHER_EN, default 1, meaning 1 = ordered dither enabled and 0 = plain truncation (c[7:6]).
REQ-002 The block SHALL have parameter TEMPORAL_EN, default 1, meaning 1 = dither matrix index rotates per frame.
REQ-003 The block SHALL have parameter SYNC_INVERT, default 0, meaning 1 = hsync/vsync inverted at the output.
REQ-004 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  pixel clock, 25.175 MHz
- rst_n  in  1  reset; synchronous, active-low
- hpos  in  10  beam x from the sync generator
- vpos  in  10  beam y from the sync generator
- display_on  in  1  visible-area flag
- hsync_in  in  1  active-high hsync
- vsync_in  in  1  active-high vsync
- r_in, g_in, b_in  in  8 each  effect colour, 8 bits per channel
- pattern_sel  in  2  0 = pass, 1 = grey ramp, 2 = colour bars, 3 = checker
- uo_out  out  8  TinyVGA PMOD {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}, registered

Function
REQ-005 The block SHALL use a 2-stage pipeline: inputs sampled at edge N appear on uo_out after edge N+2, and sync, blanking and colour SHALL all share that same latency.
REQ-006 The block SHALL detect a vsync rising edge as vsync_in=1 while the registered previous vsync_in=0; vsync held high for many cycles SHALL count as a single edge.
REQ-007 On each vsync rising edge, the 2-bit frame_cnt SHALL increment and wrap from 3 to 0.
REQ-008 On each vsync rising edge, pattern_sel SHALL be latched into active_pat; a change of pattern_sel mid-frame SHALL have no effect until the next edge.
REQ-009 The stage-1 source mux SHALL select per active_pat:
- 0: r/g/b_in
- 1: all channels = hpos[9:2]
- 2: bar = hpos[9:7]; r = {8{bar[2]}}, g = {8{bar[1]}}, b = {8{bar[0]}}
- 3: all channels = {8{hpos[5]^vpos[5]}}
REQ-010 The dither index SHALL be xi = hpos[1:0] + frame_cnt and yi = vpos[1:0] + frame_cnt, both mod 4, when TEMPORAL_EN=1, and xi = hpos[1:0], yi = vpos[1:0] otherwise.
REQ-011 The threshold SHALL be t = bayer[yi][xi] << 2 (range 0..60), with bayer rows 0,8,2,10 / 12,4,14,6 / 3,11,1,9 / 15,7,13,5.
REQ-012 Each channel output SHALL be q = min(3, (c + t) >> 6), computed with a 9-bit sum and saturating at 3; with DITHER_EN=0, q SHALL be c[7:6].
REQ-013 When the sampled display_on=0, all colour bits SHALL be 0, taking priority over the source mux and dither.
REQ-014 The sync bits SHALL equal the delayed hsync_in/vsync_in XOR SYNC_INVERT.

Reset
REQ-015 While rst_n=0 at a clock edge, the block SHALL clear all pipeline registers, frame_cnt, active_pat and the previous-vsync register to 0, and set uo_out to 8'h00.
REQ-016 Reset asserted mid-frame SHALL take effect on the next edge with no partial pixel emitted, and the first valid output SHALL appear 2 cycles after rst_n rises.

Structure
REQ-017 A shared package SHALL hold the Bayer 4x4 constant table, the pattern_sel encodings, and the PMOD bit-position constants.
REQ-018 The per-channel quantiser (REQ-012) SHALL be one sub-module, dither_quant, instantiated 3 times.

Verification
REQ-019 Scenario: pattern 0, c=0x80, hpos=0, vpos=0, frame_cnt=0 -> q=2'b10 on all channels exactly 2 cycles later.
REQ-020 Scenario: c=0xFF, hpos=0, vpos=3 (t=60) -> sum 315 saturates to q=3; c=0x3C, hpos=3, vpos=0 (t=40) -> q=1.
REQ-021 Scenario: TEMPORAL_EN=1, one vsync rising edge (frame_cnt=1), hpos=3, vpos=3 -> xi=yi=0, t=0, c=0x3C gives q=0.
REQ-022 Scenario: pattern_sel changes 0->3 mid-frame -> output unchanged until after the next vsync rise, then checker with white at hpos=32, vpos=0.
REQ-023 Scenario: display_on=0 with c=0xFF -> colour bits 0 while sync bits still track inputs delayed by 2; SYNC_INVERT=1 inverts bits 7 and 3.
REQ-024 Scenario: vsync_in held high for 2 lines -> frame_cnt advances by exactly 1; rst_n low mid-line -> uo_out=0x00 on the next edge.
